// File: rtl/apb_byte_mem_slave.sv
// APB4 completer over a byte-addressed storage array with programmable wait states.
// Optional macro APB_PROT_CHECK_EN rejects unprivileged writes (PPROT[0] = 0) with PSLVERR.
module apb_byte_mem_slave #(
  parameter int unsigned NumWords   = 64,
  parameter int unsigned WaitStates = 1
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  input  logic [3:0]  PSTRB,
  input  logic [2:0]  PPROT,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR
);

  localparam int unsigned AW = $clog2(NumWords);

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] off_q, off_d;
  logic          write_q, write_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    strb_q, strb_d;
  logic [7:0]    mem_q [NumWords];
  logic [7:0]    mem_d [NumWords];

  logic [1:0]    hi_lane;
  logic [AW:0]   lane_end;
  logic          ovf_err;
  logic          prot_err;
  logic          err;
  logic          complete;
  logic [31:0]   rd_word;
  logic          unused_ok;

`ifdef APB_PROT_CHECK_EN
  logic prot0_q, prot0_d;
  assign prot_err  = write_q && !prot0_q;
  assign unused_ok = ^{PADDR[31:AW], PPROT[2:1]};
`else
  assign prot_err  = 1'b0;
  assign unused_ok = ^{PADDR[31:AW], PPROT};
`endif

  // Highest lane touched decides overflow; AW+1 bits keep the carry visible.
  always_comb begin
    hi_lane = 2'd0;
    if (!write_q || strb_q[3]) hi_lane = 2'd3;
    else if (strb_q[2])        hi_lane = 2'd2;
    else if (strb_q[1])        hi_lane = 2'd1;
    lane_end = {1'b0, off_q} + (AW+1)'(hi_lane);
    ovf_err  = (lane_end >= (AW+1)'(NumWords)) && (!write_q || (strb_q != 4'b0000));
    err      = ovf_err || prot_err;
  end

  always_comb begin
    rd_word = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      rd_word[8*i +: 8] = mem_q[off_q + AW'(i)];
    end
  end

  assign complete = (state_q == ACCESS) && PSEL && PENABLE && (cnt_q == 4'd0);
  assign PREADY   = complete;
  assign PSLVERR  = complete && err;
  assign PRDATA   = (complete && !write_q && !err) ? rd_word : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    off_d   = off_q;
    write_d = write_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    mem_d   = mem_q;
`ifdef APB_PROT_CHECK_EN
    prot0_d = prot0_q;
`endif
    case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          off_d   = PADDR[AW-1:0];
          write_d = PWRITE;
          wdata_d = PWDATA;
          strb_d  = PSTRB;
          cnt_d   = 4'(WaitStates);
`ifdef APB_PROT_CHECK_EN
          prot0_d = PPROT[0];
`endif
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!(PSEL && PENABLE)) begin
          state_d = IDLE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = IDLE;
          if (write_q && !err) begin
            for (int unsigned i = 0; i < 4; i++) begin
              if (strb_q[i]) mem_d[off_q + AW'(i)] = wdata_q[8*i +: 8];
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      off_q   <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
`ifdef APB_PROT_CHECK_EN
      prot0_q <= 1'b0;
`endif
      for (int unsigned i = 0; i < NumWords; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      off_q   <= off_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
`ifdef APB_PROT_CHECK_EN
      prot0_q <= prot0_d;
`endif
      mem_q   <= mem_d;
    end
  end

endmodule

// File: tb/tb_apb_byte_mem_slave.sv
// Scoreboard bench for apb_byte_mem_slave: three instances with 1, 15 and 0 wait states.
module tb_apb_byte_mem_slave;

  localparam int NW = 64;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        pclk = 1'b0;
  logic        presetn = 1'b1;
  logic [2:0]  psel = '0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic [2:0]  pprot = '0;
  logic [31:0] prdata [3];
  logic [2:0]  pready;
  logic [2:0]  pslverr;

  logic [7:0]  mdl [3][NW];
  exp_t        sb[$];
  int          tests_run = 0;
  int          tests_failed = 0;

  always #5 pclk = ~pclk;

  apb_byte_mem_slave #(.NumWords(64), .WaitStates(1)) u_dut_w1 (
    .PCLK(pclk), .PRESETn(presetn), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
    .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));

  apb_byte_mem_slave #(.NumWords(64), .WaitStates(15)) u_dut_w15 (
    .PCLK(pclk), .PRESETn(presetn), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
    .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));

  apb_byte_mem_slave #(.NumWords(64), .WaitStates(0)) u_dut_w0 (
    .PCLK(pclk), .PRESETn(presetn), .PSEL(psel[2]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
    .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]));

  function automatic int ws_of(input int d);
    return (d == 0) ? 1 : (d == 1) ? 15 : 0;
  endfunction

  function automatic void mdl_clear();
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < NW; i++) mdl[d][i] = 8'h00;
  endfunction

  // Reference behaviour: overflow/protection error, strobed write, little-endian read.
  function automatic exp_t sb_model(input int d, input logic wr, input logic [31:0] addr,
                                    input logic [31:0] wd, input logic [3:0] st,
                                    input logic [2:0] prot);
    exp_t e;
    int   off;
    int   h;
    off     = int'(addr[5:0]);
    e.rdata = '0;
    e.err   = 1'b0;
    if (wr) begin
      h = -1;
      for (int i = 0; i < 4; i++) if (st[i]) h = i;
      e.err = (h >= 0) && (off + h >= NW);
`ifdef APB_PROT_CHECK_EN
      if (!prot[0]) e.err = 1'b1;
`endif
      if (!e.err)
        for (int i = 0; i < 4; i++) if (st[i]) mdl[d][off + i] = wd[8*i +: 8];
    end else begin
      e.err = (off + 3 >= NW);
      if (!e.err)
        for (int i = 0; i < 4; i++) e.rdata[8*i +: 8] = mdl[d][off + i];
    end
    return e;
  endfunction

  task automatic bus_idle();
    @(posedge pclk); #1;
    psel    = '0;
    penable = 1'b0;
  endtask

  task automatic apb_xfer(input int d, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] st, input logic [2:0] prot,
                          input string tag);
    exp_t e;
    int   n;
    bit   done;
    @(posedge pclk); #1;
    psel    = '0;
    psel[d] = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wd;
    pstrb   = st;
    pprot   = prot;
    sb.push_back(sb_model(d, wr, addr, wd, st, prot));
    @(posedge pclk); #1;
    penable = 1'b1;
    n    = 1;
    done = 1'b0;
    while (!done && n <= 40) begin
      @(negedge pclk);
      if (pready[d]) begin
        done = 1'b1;
        e = sb.pop_front();
        tests_run++;
        if (prdata[d] !== e.rdata) begin
          tests_failed++;
          $display("FAIL %s prdata: got %h expected %h", tag, prdata[d], e.rdata);
        end
        tests_run++;
        if (pslverr[d] !== e.err) begin
          tests_failed++;
          $display("FAIL %s pslverr: got %b expected %b", tag, pslverr[d], e.err);
        end
        tests_run++;
        if (n != ws_of(d) + 1) begin
          tests_failed++;
          $display("FAIL %s latency: got %0d access cycles expected %0d", tag, n, ws_of(d) + 1);
        end
      end else begin
        tests_run++;
        if (prdata[d] !== 32'h0 || pslverr[d] !== 1'b0) begin
          tests_failed++;
          $display("FAIL %s wait_outputs: got prdata %h pslverr %b expected 0/0",
                   tag, prdata[d], pslverr[d]);
        end
        n++;
      end
    end
    if (!done) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s timeout: got no PREADY in %0d cycles expected %0d", tag, n - 1, ws_of(d) + 1);
      void'(sb.pop_front());
    end
  endtask

  task automatic test_reset();
    presetn = 1'b0;
    mdl_clear();
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    for (int d = 0; d < 3; d++) begin
      tests_run++;
      if (pready[d] !== 1'b0 || pslverr[d] !== 1'b0 || prdata[d] !== 32'h0) begin
        tests_failed++;
        $display("FAIL reset_outputs[%0d]: got %b/%b/%h expected 0/0/0",
                 d, pready[d], pslverr[d], prdata[d]);
      end
    end
    @(posedge pclk); #1;
    presetn = 1'b1;
    apb_xfer(0, 1'b0, 32'h00, '0, 4'h0, 3'b001, "rd_after_reset");
    bus_idle();
  endtask

  task automatic test_full_write();
    apb_xfer(0, 1'b1, 32'h04, 32'hDEADBEEF, 4'b1111, 3'b001, "wr_04");
    apb_xfer(0, 1'b0, 32'h04, '0, 4'h0, 3'b001, "rd_04");
    apb_xfer(0, 1'b0, 32'h05, '0, 4'h0, 3'b001, "rd_05");
    apb_xfer(0, 1'b0, 32'hFFFF_FF44, '0, 4'h0, 3'b001, "rd_alias_44");
    bus_idle();
  endtask

  task automatic test_strobe();
    apb_xfer(0, 1'b1, 32'h10, 32'h11223344, 4'b0101, 3'b001, "wr_10_strb");
    apb_xfer(0, 1'b0, 32'h10, '0, 4'h0, 3'b001, "rd_10");
    apb_xfer(0, 1'b1, 32'h3F, 32'hFFFFFFFF, 4'b0000, 3'b001, "wr_3f_nostrb");
    bus_idle();
  endtask

  task automatic test_boundary();
    apb_xfer(0, 1'b1, 32'h3E, 32'hCAFE1234, 4'b0011, 3'b001, "wr_3e_ok");
    apb_xfer(0, 1'b1, 32'h3E, 32'h00990000, 4'b0100, 3'b001, "wr_3e_ovf");
    apb_xfer(0, 1'b0, 32'h3D, '0, 4'h0, 3'b001, "rd_3d_ovf");
    apb_xfer(0, 1'b0, 32'h3C, '0, 4'h0, 3'b001, "rd_3c");
    apb_xfer(0, 1'b1, 32'h3D, 32'h0000AA00, 4'b0010, 3'b001, "wr_3d_lane1");
    apb_xfer(0, 1'b0, 32'h3C, '0, 4'h0, 3'b001, "rd_3c_again");
    bus_idle();
  endtask

  task automatic test_latency();
    apb_xfer(2, 1'b1, 32'h20, 32'h0BADF00D, 4'b1111, 3'b001, "w0_wr");
    apb_xfer(2, 1'b0, 32'h20, '0, 4'h0, 3'b001, "w0_rd");
    apb_xfer(1, 1'b1, 32'h30, 32'h76543210, 4'b1110, 3'b001, "w15_wr");
    apb_xfer(1, 1'b0, 32'h30, '0, 4'h0, 3'b001, "w15_rd");
    bus_idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    logic [31:0] w;
    logic [3:0]  s;
    logic        wr;
    int          d;
    for (int k = 0; k < 16; k++) begin
      d  = (k % 4 == 3) ? 2 : 0;
      wr = ($urandom_range(0, 1) == 1);
      a  = {$urandom_range(0, 255), 8'h00, 8'h00, 2'b00, 6'($urandom_range(0, 63))};
      w  = $urandom;
      s  = 4'($urandom_range(0, 15));
      apb_xfer(d, wr, a, w, s, 3'b001, "b2b");
    end
    bus_idle();
  endtask

  task automatic test_abort();
    @(posedge pclk); #1;
    psel    = 3'b001;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 32'h04;
    pwdata  = 32'hFFFFFFFF;
    pstrb   = 4'b1111;
    pprot   = 3'b001;
    @(posedge pclk); #1;
    psel    = '0;
    @(negedge pclk);
    tests_run++;
    if (pready[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_pready: got %b expected 0", pready[0]);
    end
    apb_xfer(0, 1'b0, 32'h04, '0, 4'h0, 3'b001, "rd_after_abort");
    bus_idle();
  endtask

  task automatic test_prot();
    apb_xfer(0, 1'b1, 32'h08, 32'h55AA55AA, 4'b1111, 3'b000, "wr_08_unpriv");
    apb_xfer(0, 1'b0, 32'h08, '0, 4'h0, 3'b000, "rd_08_a");
    apb_xfer(0, 1'b1, 32'h08, 32'h13579BDF, 4'b1111, 3'b001, "wr_08_priv");
    apb_xfer(0, 1'b0, 32'h08, '0, 4'h0, 3'b000, "rd_08_b");
    bus_idle();
  endtask

  task automatic test_reset_mid_access();
    apb_xfer(1, 1'b1, 32'h24, 32'h01020304, 4'b1111, 3'b001, "w15_prewr");
    @(posedge pclk); #1;
    psel    = 3'b010;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 32'h24;
    pwdata  = 32'hA5A5A5A5;
    pstrb   = 4'b1111;
    pprot   = 3'b001;
    @(posedge pclk); #1;
    penable = 1'b1;
    repeat (4) @(posedge pclk);
    #2;
    presetn = 1'b0;
    mdl_clear();
    #1;
    tests_run++;
    if (pready[1] !== 1'b0 || pslverr[1] !== 1'b0 || prdata[1] !== 32'h0) begin
      tests_failed++;
      $display("FAIL midreset_outputs: got %b/%b/%h expected 0/0/0",
               pready[1], pslverr[1], prdata[1]);
    end
    psel    = '0;
    penable = 1'b0;
    @(posedge pclk); #1;
    presetn = 1'b1;
    apb_xfer(1, 1'b0, 32'h24, '0, 4'h0, 3'b001, "w15_rd_after_reset");
    apb_xfer(0, 1'b0, 32'h04, '0, 4'h0, 3'b001, "w1_rd_after_reset");
    bus_idle();
  endtask

  initial begin
    #1;
    test_reset();
    test_full_write();
    test_strobe();
    test_boundary();
    test_latency();
    test_abort();
    test_back_to_back();
    test_prot();
    test_reset_mid_access();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
